// File: rtl/dac_pkg.sv
// Shared definitions for the DAC serial transmitter: frame geometry,
// power-down encodings and FSM state encoding.
package dac_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] pd,
                                                     input logic [DATA_W-1:0] sample);
    return {2'b00, pd, sample};
  endfunction

endpackage

// File: rtl/contador_medio_periodo.sv
// Half-period counter: tick marks the last cycle of each CLK_DIV-cycle slot,
// wrap toggles on every tick so callers can tell first and second halves apart.
module contador_medio_periodo
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic Clock_Nexys,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic wrap
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
        wrap  <= ~wrap;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/protocolo_dac.sv
// DAC121S101-style serial transmitter: 16-bit frame, SCLK from a clock-enable
// divider, SYNC framing and a quiet gap before the next frame.
module protocolo_dac
  import dac_pkg::*;
#(
  parameter int         CLK_DIV = 5,
  parameter logic [1:0] PD_MODE = PD_NORMAL
) (
  input  logic              Clock_Nexys,
  input  logic              Reset,
  input  logic              start,
  input  logic [DATA_W-1:0] Dato,
  output logic              busy,
  output logic              done,
  output logic              SYNC,
  output logic              SCLK,
  output logic              data_DAC
);

  state_t state, next_state;

  logic [FRAME_W-1:0] frame_in;
  logic [FRAME_W-2:0] shreg;
  logic [BIT_W-1:0]   bitcnt;
  logic               tick, wrap;
  logic               load, fall, shift, frame_end, quiet_end;

  assign frame_in = build_frame(PD_MODE, Dato);

  contador_medio_periodo #(
    .CLK_DIV (CLK_DIV)
  ) u_half (
    .Clock_Nexys (Clock_Nexys),
    .Reset       (Reset),
    .clear       (state == IDLE),
    .enable      (state != IDLE),
    .tick        (tick),
    .wrap        (wrap)
  );

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)     next_state = SHIFT;
      SHIFT:   if (frame_end) next_state = QUIET;
      QUIET:   if (quiet_end) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Falling SCLK edges leave data untouched; rising edges advance the bit or end the frame.
  always_comb begin
    load      = 1'b0;
    fall      = 1'b0;
    shift     = 1'b0;
    frame_end = 1'b0;
    quiet_end = 1'b0;
    unique case (state)
      IDLE:  load = start;
      SHIFT: if (tick) begin
               if (SCLK)             fall      = 1'b1;
               else if (bitcnt != '0) shift     = 1'b1;
               else                  frame_end = 1'b1;
             end
      QUIET: quiet_end = tick && wrap;
      default: ;
    endcase
  end

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      shreg    <= '0;
      bitcnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      SYNC     <= 1'b1;
      SCLK     <= 1'b1;
      data_DAC <= 1'b0;
    end else begin
      done <= quiet_end;
      if (load) begin
        shreg    <= frame_in[FRAME_W-2:0];
        data_DAC <= frame_in[FRAME_W-1];
        bitcnt   <= BIT_W'(FRAME_W - 1);
        SYNC     <= 1'b0;
        SCLK     <= 1'b1;
        busy     <= 1'b1;
      end
      if (fall) SCLK <= 1'b0;
      if (shift) begin
        SCLK     <= 1'b1;
        shreg    <= {shreg[FRAME_W-3:0], 1'b0};
        data_DAC <= shreg[FRAME_W-2];
        bitcnt   <= bitcnt - 1'b1;
      end
      if (frame_end) begin
        SCLK     <= 1'b1;
        SYNC     <= 1'b1;
        data_DAC <= 1'b0;
      end
      if (quiet_end) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_protocolo_dac.sv
// Directed bench for protocolo_dac: three instances cover CLK_DIV=5/PD=00,
// CLK_DIV=5/PD=11 and CLK_DIV=1; a bench-side shifter captures data on SCLK falls.
module tb_protocolo_dac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  start;
  logic [11:0] dato [3];
  wire  [2:0]  busy, done, sync, sclk, dat;

  int vectors     = 0;
  int miscompares = 0;

  protocolo_dac #(.CLK_DIV(5), .PD_MODE(2'b00)) dut_a (
    .Clock_Nexys(clk), .Reset(rst[0]), .start(start[0]), .Dato(dato[0]),
    .busy(busy[0]), .done(done[0]), .SYNC(sync[0]), .SCLK(sclk[0]), .data_DAC(dat[0]));

  protocolo_dac #(.CLK_DIV(5), .PD_MODE(2'b11)) dut_b (
    .Clock_Nexys(clk), .Reset(rst[1]), .start(start[1]), .Dato(dato[1]),
    .busy(busy[1]), .done(done[1]), .SYNC(sync[1]), .SCLK(sclk[1]), .data_DAC(dat[1]));

  protocolo_dac #(.CLK_DIV(1), .PD_MODE(2'b00)) dut_c (
    .Clock_Nexys(clk), .Reset(rst[2]), .start(start[2]), .Dato(dato[2]),
    .busy(busy[2]), .done(done[2]), .SYNC(sync[2]), .SCLK(sclk[2]), .data_DAC(dat[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One frame on instance k; start is sampled at the edge ending cycle t0, loop index n is cycle t0+n.
  task automatic run_frame(input int k, input int c, input logic [11:0] d,
                           input logic [15:0] want, input bit change_mid,
                           input bit extra_start, input string tag);
    int first_low = -1, last_low = -1, low_cnt = 0, falls = 0, stray = 0;
    int done_cnt = 0, done_at = -1;
    logic [15:0] cap = '0;
    logic prev_sclk = 1'b1;
    @(negedge clk);
    dato[k]  = d;
    start[k] = 1'b1;
    for (int n = 1; n <= 34*c + 3; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start[k] = 1'b0;
        check_val({tag, " first_bit"}, dat[k], want[15]);
        check_val({tag, " busy_on"}, busy[k], 1);
        check_val({tag, " sclk_start"}, sclk[k], 1);
      end
      if (!sync[k]) begin
        low_cnt++;
        if (first_low < 0) first_low = n;
        last_low = n;
      end
      if (prev_sclk && !sclk[k]) begin
        if (!sync[k]) begin
          cap = {cap[14:0], dat[k]};
          falls++;
        end else stray++;
      end
      if (sync[k] && !sclk[k]) stray++;
      if (done[k]) begin
        done_cnt++;
        done_at = n;
        check_val({tag, " busy_at_done"}, busy[k], 0);
      end
      if (change_mid && n == 20) dato[k] = 12'hFFF;
      if (extra_start && n == 50) start[k] = 1'b1;
      if (extra_start && n == 51) start[k] = 1'b0;
      prev_sclk = sclk[k];
    end
    check_val({tag, " sync_first"}, first_low, 1);
    check_val({tag, " sync_last"}, last_low, 32*c);
    check_val({tag, " sync_len"}, low_cnt, 32*c);
    check_val({tag, " falls"}, falls, 16);
    check_val({tag, " frame"}, cap, want);
    check_val({tag, " done_cnt"}, done_cnt, 1);
    check_val({tag, " done_at"}, done_at, 34*c + 1);
    check_val({tag, " stray_sclk"}, stray, 0);
  endtask

  initial begin
    int bad, pulses, done_cnt;
    int falls_at[$];
    logic [15:0] frames[$];
    logic [15:0] cap;
    logic prev_sync, prev_sclk;

    rst   = 3'b000;
    start = 3'b000;
    for (int i = 0; i < 3; i++) dato[i] = 12'h000;

    repeat (3) @(negedge clk);
    check_val("rst sync", sync, 3'b111);
    check_val("rst sclk", sclk, 3'b111);
    check_val("rst data", dat, 3'b000);
    check_val("rst busy", busy, 3'b000);
    check_val("rst done", done, 3'b000);
    rst = 3'b111;

    bad = 0;
    pulses = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sync !== 3'b111 || sclk !== 3'b111 || dat !== 3'b000 || busy !== 3'b000) bad++;
      if (done !== 3'b000) pulses++;
    end
    check_val("idle outputs", bad, 0);
    check_val("idle done", pulses, 0);

    run_frame(0, 5, 12'hA5C, 16'h0A5C, 1'b0, 1'b1, "a5c");
    run_frame(1, 5, 12'h000, 16'h3000, 1'b1, 1'b0, "pd11");

    // Back-to-back frames with start held high.
    cap = '0;
    prev_sync = 1'b1;
    prev_sclk = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    dato[0]  = 12'h001;
    start[0] = 1'b1;
    for (int n = 1; n <= 345; n++) begin
      @(negedge clk);
      if (n == 10)  dato[0]  = 12'h800;
      if (n == 172) start[0] = 1'b0;
      if (prev_sync && !sync[0]) falls_at.push_back(n);
      if (!prev_sync && sync[0]) begin
        frames.push_back(cap);
        cap = '0;
      end
      if (prev_sclk && !sclk[0] && !sync[0]) cap = {cap[14:0], dat[0]};
      if (done[0]) done_cnt++;
      prev_sync = sync[0];
      prev_sclk = sclk[0];
    end
    check_val("b2b sync_falls", falls_at.size(), 2);
    check_val("b2b fall0", (falls_at.size() > 0) ? falls_at[0] : -1, 1);
    check_val("b2b fall1", (falls_at.size() > 1) ? falls_at[1] : -1, 172);
    check_val("b2b frames", frames.size(), 2);
    check_val("b2b frame0", (frames.size() > 0) ? frames[0] : 16'hDEAD, 16'h0001);
    check_val("b2b frame1", (frames.size() > 1) ? frames[1] : 16'hDEAD, 16'h0800);
    check_val("b2b done_cnt", done_cnt, 2);

    // Reset in the middle of a frame.
    @(negedge clk);
    dato[0]  = 12'h123;
    start[0] = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) start[0] = 1'b0;
    end
    check_val("midrst pre_sync", sync[0], 0);
    rst[0] = 1'b0;
    #1;
    check_val("midrst sync", sync[0], 1);
    check_val("midrst sclk", sclk[0], 1);
    check_val("midrst data", dat[0], 0);
    check_val("midrst busy", busy[0], 0);
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    bad = 0;
    pulses = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sync[0] !== 1'b1 || sclk[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      if (done[0] !== 1'b0) pulses++;
    end
    check_val("midrst quiet", bad, 0);
    check_val("midrst no_done", pulses, 0);
    run_frame(0, 5, 12'h3C3, 16'h03C3, 1'b0, 1'b0, "after_rst");

    run_frame(2, 1, 12'hFFF, 16'h0FFF, 1'b0, 1'b0, "div1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
